// File: rtl/ddr_port_arbiter.sv
// Shares the single DDR block port between the I-cache refill path and the
// D-cache refill/writeback path, one registered transaction at a time.
module ddr_port_arbiter #(
    parameter int MAX_DC_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ic_req,
    input  logic [29:0]  ic_addr,
    output logic         ic_done,
    input  logic         dc_req,
    input  logic         dc_write,
    input  logic [29:0]  dc_addr,
    input  logic [255:0] dc_wdata,
    output logic         dc_done,
    output logic [255:0] block_out,
    output logic         ram_en,
    output logic         ram_write,
    output logic [26:0]  ram_addr,
    output logic [255:0] ram_wdata,
    input  logic         ram_rdy,
    input  logic [255:0] ram_rdata,
    output logic         busy,
    output logic         owner,
    output logic         timeout_err
);

    localparam logic [1:0]  ST_IDLE    = 2'd0;
    localparam logic [1:0]  ST_ISSUE   = 2'd1;
    localparam logic [1:0]  ST_DONE    = 2'd2;
    localparam logic [1:0]  ST_GAP     = 2'd3;
    localparam logic [3:0]  STREAK_MAX = 4'(MAX_DC_STREAK);
    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]   state_q, state_d;
    logic         owner_q, owner_d;
    logic         ram_en_q, ram_en_d;
    logic         ram_write_q, ram_write_d;
    logic [26:0]  ram_addr_q, ram_addr_d;
    logic [255:0] ram_wdata_q, ram_wdata_d;
    logic [255:0] block_out_q, block_out_d;
    logic         ic_done_q, ic_done_d;
    logic         dc_done_q, dc_done_d;
    logic         timeout_err_q, timeout_err_d;
    logic [3:0]   streak_q, streak_d;
    logic [15:0]  timer_q, timer_d;
    logic         grant_ic, grant_dc;
    logic         addr_lsb_unused;

    // Word-offset bits inside a 256-bit block never reach the DDR port.
    assign addr_lsb_unused = ^{ic_addr[2:0], dc_addr[2:0]};

    always_comb begin
        grant_dc = (state_q == ST_IDLE) && dc_req && !(ic_req && (streak_q == STREAK_MAX));
        grant_ic = (state_q == ST_IDLE) && ic_req && !grant_dc;
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        ram_write_d   = ram_write_q;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        block_out_d   = block_out_q;
        timeout_err_d = timeout_err_q;
        streak_d      = streak_q;
        timer_d       = timer_q;
        // Handshake outputs lag the state by one edge so the done cycle sees ram_en low.
        ram_en_d      = (state_q == ST_ISSUE);
        ic_done_d     = (state_q == ST_DONE) && !owner_q;
        dc_done_d     = (state_q == ST_DONE) && owner_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_ic) begin
                    owner_d     = 1'b0;
                    ram_addr_d  = ic_addr[29:3];
                    ram_write_d = 1'b0;
                    streak_d    = 4'd0;
                    state_d     = ST_ISSUE;
                end else if (grant_dc) begin
                    owner_d     = 1'b1;
                    ram_addr_d  = dc_addr[29:3];
                    ram_write_d = dc_write;
                    ram_wdata_d = dc_wdata;
                    // Only count D-cache wins that actually made the I-cache wait.
                    if (!ic_req) begin
                        streak_d = 4'd0;
                    end else if (streak_q < STREAK_MAX) begin
                        streak_d = streak_q + 4'd1;
                    end
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = timer_q + 16'd1;
                if (ram_rdy) begin
                    block_out_d = ram_rdata;
                    state_d     = ST_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_err_d = 1'b1;
                    block_out_d   = '0;
                    state_d       = ST_DONE;
                end
            end
            ST_DONE: begin
                timer_d = 16'd0;
                state_d = ST_GAP;
            end
            default: begin
                // Wait for the controller to release ram_rdy so the requester can drop req.
                if (!ram_rdy) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_write_q   <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            block_out_q   <= '0;
            ic_done_q     <= 1'b0;
            dc_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            streak_q      <= 4'd0;
            timer_q       <= 16'd0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            ram_en_q      <= ram_en_d;
            ram_write_q   <= ram_write_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            block_out_q   <= block_out_d;
            ic_done_q     <= ic_done_d;
            dc_done_q     <= dc_done_d;
            timeout_err_q <= timeout_err_d;
            streak_q      <= streak_d;
            timer_q       <= timer_d;
        end
    end

    assign ic_done     = ic_done_q;
    assign dc_done     = dc_done_q;
    assign block_out   = block_out_q;
    assign ram_en      = ram_en_q;
    assign ram_write   = ram_write_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign busy        = (state_q != ST_IDLE);
    assign owner       = owner_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter with a small level-handshake DDR responder.
module tb_ddr_port_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_req = 1'b0;
    logic [29:0]  ic_addr = '0;
    logic         ic_done;
    logic         dc_req = 1'b0;
    logic         dc_write = 1'b0;
    logic [29:0]  dc_addr = '0;
    logic [255:0] dc_wdata = '0;
    logic         dc_done;
    logic [255:0] block_out;
    logic         ram_en;
    logic         ram_write;
    logic [26:0]  ram_addr;
    logic [255:0] ram_wdata;
    logic         ram_rdy = 1'b0;
    logic [255:0] ram_rdata = '0;
    logic         busy;
    logic         owner;
    logic         timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int both_err = 0;

    int rdy_delay = 5;
    int rdy_extra = 0;
    bit rdy_never = 1'b0;
    int en_cnt = 0;
    int hold_cnt = 0;

    int           en_first, en_hi, done_at, ic_n, dc_n;
    logic [255:0] blk, wd;
    logic [26:0]  addr;
    logic         wr, own;

    localparam logic [255:0] RD_A5 = {32{8'hA5}};
    localparam logic [255:0] WB    = {8{32'h1234_5678}};
    localparam logic [255:0] RD_DB = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] RD_01 = {4{64'h0123_4567_89AB_CDEF}};

    ddr_port_arbiter #(.MAX_DC_STREAK(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done),
        .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_done(dc_done), .block_out(block_out),
        .ram_en(ram_en), .ram_write(ram_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdy(ram_rdy), .ram_rdata(ram_rdata),
        .busy(busy), .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Responder: raises ram_rdy rdy_delay cycles into ram_en, releases rdy_extra cycles after ram_en drops.
    always @(posedge clk) begin
        #2;
        if (ram_en) begin
            hold_cnt = 0;
            if (!rdy_never) begin
                en_cnt++;
                if (en_cnt >= rdy_delay) ram_rdy = 1'b1;
            end
        end else begin
            en_cnt = 0;
            if (ram_rdy) begin
                if (hold_cnt >= rdy_extra) begin
                    ram_rdy  = 1'b0;
                    hold_cnt = 0;
                end else begin
                    hold_cnt++;
                end
            end
        end
    end

    always @(negedge clk) if (ic_done && dc_done) both_err++;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Runs one transaction window; scrambles requester inputs right after grant.
    task automatic run_txn(input int win);
        en_first = -1; en_hi = 0; done_at = -1; ic_n = 0; dc_n = 0;
        blk = '0; wd = '0; addr = '0; wr = 1'b0; own = 1'b0;
        for (int n = 1; n <= win; n++) begin
            @(negedge clk);
            if (n == 1) begin
                ic_addr  = 30'h2AAA_AAAA;
                dc_addr  = 30'h1555_5555;
                dc_wdata = '1;
                dc_write = ~dc_write;
            end
            if (ram_en) begin
                en_hi++;
                if (en_first < 0) begin
                    en_first = n; addr = ram_addr; wr = ram_write; wd = ram_wdata; own = owner;
                end
            end
            if ((ic_done || dc_done) && done_at < 0) begin
                done_at = n; blk = block_out;
                ic_req = 1'b0; dc_req = 1'b0;
            end
            ic_n += int'(ic_done);
            dc_n += int'(dc_done);
        end
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle", 256'(busy), 256'(1'b0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ngr, gap_n, bad, en2, done1, dc2, dones;
        logic [9:0]  seq;
        logic        en_prev, seen;
        logic [26:0] addr2;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ctrl", 256'({busy, ram_en, ram_write, ic_done, dc_done, owner, timeout_err}), 256'(7'd0));
        check("rst_addr", 256'(ram_addr), 256'(27'd0));
        check("rst_wdata", ram_wdata, '0);
        check("rst_block", block_out, '0);
        rst = 1'b0;
        @(negedge clk);

        // Single I-cache read
        ic_req = 1'b1; ic_addr = 30'h0000_0128; ram_rdata = RD_A5; rdy_delay = 5;
        run_txn(12);
        check("ic_en_latency", 256'(en_first), 256'(2));
        check("ic_done_latency", 256'(done_at), 256'(8));
        check("ic_addr", 256'(addr), 256'(27'h25));
        check("ic_write", 256'(wr), 256'(1'b0));
        check("ic_owner", 256'(own), 256'(1'b0));
        check("ic_done_cnt", 256'(ic_n), 256'(1));
        check("ic_dc_done_cnt", 256'(dc_n), 256'(0));
        check("ic_block", blk, RD_A5);

        // D-cache writeback; block_out still captures ram_rdata
        dc_req = 1'b1; dc_write = 1'b1; dc_addr = 30'h3FFF_FFF8; dc_wdata = WB;
        ram_rdata = RD_DB; rdy_delay = 3;
        run_txn(10);
        check("dc_addr", 256'(addr), 256'(27'h7FF_FFFF));
        check("dc_write", 256'(wr), 256'(1'b1));
        check("dc_wdata", wd, WB);
        check("dc_owner", 256'(own), 256'(1'b1));
        check("dc_done_latency", 256'(done_at), 256'(6));
        check("dc_done_cnt", 256'(dc_n), 256'(1));
        check("dc_ic_done_cnt", 256'(ic_n), 256'(0));
        check("dc_block", blk, RD_DB);

        // Starvation guard: both requests held
        ic_req = 1'b1; dc_req = 1'b1; dc_write = 1'b0; rdy_delay = 2;
        ngr = 0; seq = '0; en_prev = 1'b0;
        for (int n = 0; n < 100 && ngr < 10; n++) begin
            @(negedge clk);
            if (ram_en && !en_prev) begin
                seq[ngr] = owner;
                ngr++;
            end
            en_prev = ram_en;
        end
        ic_req = 1'b0; dc_req = 1'b0;
        check("starve_grants", 256'(ngr), 256'(10));
        check("starve_order", 256'(seq), 256'(10'b01_1110_1111));
        wait_idle(30);

        // Slow ram_rdy release holds the arbiter in GAP
        ic_req = 1'b1; ic_addr = 30'h200; rdy_delay = 2; rdy_extra = 6; ram_rdata = RD_A5;
        seen = 1'b0; gap_n = 0; bad = 0; en2 = -1; done1 = -1; dc2 = 0; addr2 = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (seen && en2 < 0 && ram_en) begin
                en2 = n; addr2 = ram_addr;
            end
            if (seen && en2 < 0 && ram_rdy) begin
                gap_n++;
                if (!busy || ram_en) bad++;
            end
            if (ic_done && !seen) begin
                seen = 1'b1; done1 = n; ic_req = 1'b0;
                dc_req = 1'b1; dc_write = 1'b0; dc_addr = 30'h40;
            end
            if (dc_done) dc_req = 1'b0;
            dc2 += int'(dc_done);
        end
        rdy_extra = 0;
        check("gap_done_at", 256'(done1), 256'(5));
        check("gap_rdy_seen", 256'(gap_n >= 4), 256'(1'b1));
        check("gap_hold_viol", 256'(bad), 256'(0));
        check("gap_next_en", 256'(en2), 256'(14));
        check("gap_dc_addr", 256'(addr2), 256'(27'h8));
        check("gap_dc_done", 256'(dc2), 256'(1));
        wait_idle(30);

        // Timeout with ram_rdy never asserted
        check("to_pre", 256'(timeout_err), 256'(1'b0));
        rdy_never = 1'b1; ic_req = 1'b1; ic_addr = 30'h1000;
        run_txn(24);
        check("to_en_cycles", 256'(en_hi), 256'(16));
        check("to_done_at", 256'(done_at), 256'(18));
        check("to_done_cnt", 256'(ic_n), 256'(1));
        check("to_block", blk, '0);
        check("to_flag", 256'(timeout_err), 256'(1'b1));
        rdy_never = 1'b0; rdy_delay = 3; ic_req = 1'b1; ic_addr = 30'h8; ram_rdata = RD_DB;
        run_txn(10);
        check("to_sticky", 256'(timeout_err), 256'(1'b1));
        check("to_after_done", 256'(ic_n), 256'(1));
        check("to_after_addr", 256'(addr), 256'(27'h1));

        // Reset three cycles into ISSUE
        rdy_never = 1'b1; dc_req = 1'b1; dc_write = 1'b0; dc_addr = 30'h100;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_en", 256'(ram_en), 256'(1'b0));
        check("mid_rst_busy", 256'(busy), 256'(1'b0));
        check("mid_rst_to", 256'(timeout_err), 256'(1'b0));
        rst = 1'b0; dc_req = 1'b0;
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            dones += int'(ic_done) + int'(dc_done);
        end
        check("mid_rst_no_done", 256'(dones), 256'(0));
        rdy_never = 1'b0; rdy_delay = 3; ram_rdata = RD_01;
        dc_req = 1'b1; dc_write = 1'b0; dc_addr = 30'h100;
        run_txn(10);
        check("post_rst_done", 256'(dc_n), 256'(1));
        check("post_rst_latency", 256'(done_at), 256'(6));
        check("post_rst_addr", 256'(addr), 256'(27'h20));
        check("post_rst_block", blk, RD_01);

        check("never_both_done", 256'(both_err), 256'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
